ram_nr_nw: RTL and testbench

RAM_NR_NW -- requirements
Module: ram_nr_nw

---
 rtl/ram_nr_nw.sv | 118 +++++++++++
 tb/tb_ram_nr_nw.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ram_nr_nw.sv
// ram_nr_nw: multi-port register-file RAM with a per-entry ready flag.
//
// Each entry holds DATA_WIDTH bits of data and a ready flag. A write stores
// data and sets ready. An alloc clears ready, and an alloc beats a same-cycle
// write to the same entry. Reads are combinational.
//
// Parameters:
//   DATA_WIDTH - entry data width in bits
//   ENTRIES    - number of entries (ENTRIES <= 2**ADDR_WIDTH)
//   ADDR_WIDTH - address width
//   NUM_RD     - number of read ports (>= 1)
//   NUM_WR     - number of write ports (>= 1)
//
// Ports:
//   clk          - clock; all state updates on the rising edge
//   rst          - asynchronous active-low reset (data -> 0, ready -> 1)
//   wr_en_i      - per-write-port enable
//   wr_addr_i    - write addresses, port k in slice k
//   wr_data_i    - write data, port k in slice k
//   alloc_en_i   - allocate (clear ready of) alloc_addr_i
//   alloc_addr_i - entry to allocate
//   rd_en_i      - per-read-port enable
//   rd_addr_i    - read addresses, port j in slice j
//   rd_data_o    - read data; 0 if disabled or out of range
//   rd_ready_o   - read ready flag; 0 if disabled or out of range
//
// Build option:
//   RAM_NR_NW_BYPASS_EN - when defined, a read of an entry that is being
//   written in the same cycle returns the write data with ready = 1.
module ram_nr_nw #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ENTRIES    = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 4,
  parameter int unsigned NUM_WR     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WR-1:0]              wr_en_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data_i,
  input  logic                           alloc_en_i,
  input  logic [ADDR_WIDTH-1:0]          alloc_addr_i,
  input  logic [NUM_RD-1:0]              rd_en_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]              rd_ready_o
);

  logic [DATA_WIDTH-1:0] data_q [ENTRIES];
  logic [DATA_WIDTH-1:0] data_d [ENTRIES];
  logic [ENTRIES-1:0]    ready_q;
  logic [ENTRIES-1:0]    ready_d;

  // Next state. Entries are matched by exact address compare, so any
  // address >= ENTRIES matches nothing and is ignored. Later (higher-index)
  // write ports override earlier ones; alloc is applied last so it wins.
  always_comb begin
    for (int e = 0; e < int'(ENTRIES); e++) begin
      data_d[e] = data_q[e];
    end
    ready_d = ready_q;
    for (int e = 0; e < int'(ENTRIES); e++) begin
      for (int k = 0; k < int'(NUM_WR); k++) begin
        if (wr_en_i[k] && (wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e))) begin
          data_d[e]  = wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
          ready_d[e] = 1'b1;
        end
      end
      if (alloc_en_i && (alloc_addr_i == ADDR_WIDTH'(e))) begin
        ready_d[e] = 1'b0;
      end
    end
  end

  // Storage; reset clears data and marks every entry ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < int'(ENTRIES); e++) begin
        data_q[e] <= '0;
      end
      ready_q <= '1;
    end else begin
      for (int e = 0; e < int'(ENTRIES); e++) begin
        data_q[e] <= data_d[e];
      end
      ready_q <= ready_d;
    end
  end

  // Combinational read ports.
  always_comb begin
    rd_data_o  = '0;
    rd_ready_o = '0;
    for (int j = 0; j < int'(NUM_RD); j++) begin
      if (rd_en_i[j]) begin
        for (int e = 0; e < int'(ENTRIES); e++) begin
          if (rd_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e)) begin
            rd_data_o[j*DATA_WIDTH +: DATA_WIDTH] = data_q[e];
            rd_ready_o[j]                         = ready_q[e];
`ifdef RAM_NR_NW_BYPASS_EN
            // Forward same-cycle write data; highest matching port wins.
            // A concurrent alloc is deliberately not reflected here.
            for (int k = 0; k < int'(NUM_WR); k++) begin
              if (rst && wr_en_i[k] &&
                  (wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e))) begin
                rd_data_o[j*DATA_WIDTH +: DATA_WIDTH] = wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                rd_ready_o[j]                         = 1'b1;
              end
            end
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_nr_nw.sv
// Directed self-checking bench for ram_nr_nw (ENTRIES=32, ADDR_WIDTH=6 so
// that out-of-range addresses such as 40 are representable).
module tb_ram_nr_nw;

  localparam int unsigned DW = 32;
  localparam int unsigned EN = 32;
  localparam int unsigned AW = 6;
  localparam int unsigned NR = 4;
  localparam int unsigned NW = 2;

  logic               clk;
  logic               rst;
  logic [NW-1:0]      wr_en;
  logic [NW*AW-1:0]   wr_addr;
  logic [NW*DW-1:0]   wr_data;
  logic               alloc_en;
  logic [AW-1:0]      alloc_addr;
  logic [NR-1:0]      rd_en;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data;
  logic [NR-1:0]      rd_ready;

  int errors = 0;
  int checks = 0;

  ram_nr_nw #(
    .DATA_WIDTH (DW),
    .ENTRIES    (EN),
    .ADDR_WIDTH (AW),
    .NUM_RD     (NR),
    .NUM_WR     (NW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .rd_en_i      (rd_en),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_ready_o   (rd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int j, input int addr, input logic en);
    rd_addr[j*AW +: AW] = AW'(addr);
    rd_en[j]            = en;
  endtask

  task automatic set_wr(input int k, input int addr, input logic [DW-1:0] d, input logic en);
    wr_addr[k*AW +: AW] = AW'(addr);
    wr_data[k*DW +: DW] = d;
    wr_en[k]            = en;
  endtask

  task automatic check_rd(input string tag, input int j,
                          input logic [DW-1:0] exp_d, input logic exp_r);
    #1;
    check({tag, "_data"}, rd_data[j*DW +: DW], exp_d);
    check({tag, "_ready"}, 32'(rd_ready[j]), 32'(exp_r));
  endtask

  initial begin
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; rd_en = '0; rd_addr = '0;

    // Writes/allocs under reset must be ignored.
    set_wr(0, 5, 32'h0000_FFFF, 1'b1);
    alloc_en = 1'b1; alloc_addr = AW'(0);
    tick();
    tick();
    wr_en = '0; alloc_en = 1'b0;
    rst = 1'b1;
    tick();

    // Post-reset state: entries 0/5/31 on all ports -> data 0, ready 1.
    for (int j = 0; j < int'(NR); j++) set_rd(j, 0, 1'b1);
    #1;
    for (int j = 0; j < int'(NR); j++) check_rd("rst_e0", j, 32'h0, 1'b1);
    for (int j = 0; j < int'(NR); j++) set_rd(j, 5, 1'b1);
    for (int j = 0; j < int'(NR); j++) check_rd("rst_e5", j, 32'h0, 1'b1);
    for (int j = 0; j < int'(NR); j++) set_rd(j, 31, 1'b1);
    for (int j = 0; j < int'(NR); j++) check_rd("rst_e31", j, 32'h0, 1'b1);

    // Alloc 7, then write 7.
    alloc_en = 1'b1; alloc_addr = AW'(7);
    tick();
    alloc_en = 1'b0;
    set_rd(0, 7, 1'b1);
    check_rd("alloc7", 0, 32'h0, 1'b0);
    set_wr(0, 7, 32'hDEAD_BEEF, 1'b1);
    tick();
    wr_en = '0;
    set_rd(1, 7, 1'b1);
    check_rd("write7", 1, 32'hDEAD_BEEF, 1'b1);

    // Both write ports hit entry 3: port 1 wins.
    set_wr(0, 3, 32'h11, 1'b1);
    set_wr(1, 3, 32'h22, 1'b1);
    tick();
    wr_en = '0;
    set_rd(2, 3, 1'b1);
    check_rd("wconf3", 2, 32'h22, 1'b1);

    // Alloc and write same entry: data stored, ready stays cleared.
    alloc_en = 1'b1; alloc_addr = AW'(9);
    set_wr(1, 9, 32'h55, 1'b1);
    tick();
    wr_en = '0; alloc_en = 1'b0;
    set_rd(3, 9, 1'b1);
    check_rd("awcol9", 3, 32'h55, 1'b0);

    // Same-cycle read of an entry being written.
    set_wr(0, 4, 32'hA5A5, 1'b1);
    set_rd(0, 4, 1'b1);
`ifdef RAM_NR_NW_BYPASS_EN
    check_rd("byp4", 0, 32'hA5A5, 1'b1);
`else
    check_rd("byp4", 0, 32'h0, 1'b1);
`endif
    tick();
    wr_en = '0;
    check_rd("after4", 0, 32'hA5A5, 1'b1);

    // Disabled read and out-of-range read.
    set_rd(0, 7, 1'b0);
    check_rd("rd_dis", 0, 32'h0, 1'b0);
    set_rd(1, 40, 1'b1);
    check_rd("rd_oor", 1, 32'h0, 1'b0);

    // Out-of-range write/alloc (40 aliases 8 in low bits) change nothing.
    set_wr(0, 40, 32'h1234, 1'b1);
    alloc_en = 1'b1; alloc_addr = AW'(40);
    set_rd(2, 40, 1'b1);
    check_rd("oor_byp", 2, 32'h0, 1'b0);
    tick();
    wr_en = '0; alloc_en = 1'b0;
    set_rd(2, 8, 1'b1);
    check_rd("oor_e8", 2, 32'h0, 1'b1);
    set_rd(3, 40, 1'b1);
    check_rd("oor_rd40", 3, 32'h0, 1'b0);

    // Mid-operation asynchronous reset discards the pending write.
    set_wr(0, 10, 32'h77, 1'b1);
    set_rd(0, 7, 1'b1);
    #2;
    rst = 1'b0;
    wr_en = '0;
    check_rd("arst_e7", 0, 32'h0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    set_rd(1, 10, 1'b1);
    check_rd("arst_e10", 1, 32'h0, 1'b1);
    set_rd(2, 9, 1'b1);
    check_rd("arst_e9", 2, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
